// File: rtl/dmem_access.sv
// Data-memory access unit for the M stage.
// Turns a load/store request into a single data-bus transaction:
// word-aligned address, byte enables and lane-replicated store data out,
// lane-selected and extended load data back. Holds the pipeline with
// stall_m until the bus acknowledges. Misaligned requests raise misalign_m
// and never reach the bus.
module dmem_access (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        mem_re_m,
  input  logic        mem_we_m,
  input  logic [31:0] alu_out_m,
  input  logic [31:0] wdata_m,
  input  logic [2:0]  funct3_m,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [31:0] mem_rdata_m,
  output logic        stall_m,
  output logic        misalign_m
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] rdata_q, rdata_d;

  logic        req;
  logic        is_half;
  logic        is_word;
  logic        misaligned;

  // funct3[1:0]: 00 byte, 01 halfword, 1x word (so 011/110/111 are words)
  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  // Store data replicated onto every lane it could land in
  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  // Lane select by address offset, then sign/zero extension (funct3[2]=1 -> unsigned)
  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3[1:0])
      2'b00:   return f3[2] ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   return f3[2] ? {16'b0, h} : {{16{h[15]}}, h};
      default: return word;
    endcase
  endfunction

  assign req        = (state_q == IDLE) && (mem_re_m || mem_we_m);
  assign is_half    = (funct3_m[1:0] == 2'b01);
  assign is_word    = funct3_m[1];
  assign misaligned = (is_half && alu_out_m[0]) || (is_word && (alu_out_m[1:0] != 2'b00));
  assign mem_rdata_m = rdata_q;

  // Next-state, latch capture and bus/stall outputs
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    f3_d       = f3_q;
    rdata_d    = rdata_q;
    bus_req    = 1'b0;
    bus_we     = 1'b0;
    bus_addr   = 32'b0;
    bus_be     = 4'b0;
    bus_wdata  = 32'b0;
    stall_m    = 1'b0;
    misalign_m = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (misaligned) begin
            misalign_m = 1'b1;
          end else begin
            stall_m = 1'b1;
            addr_d  = alu_out_m;
            be_d    = byte_en(funct3_m, alu_out_m[1:0]);
            wdata_d = store_lanes(funct3_m, wdata_m);
            we_d    = mem_we_m;   // re and we together behave as a store
            f3_d    = funct3_m;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        bus_req   = 1'b1;
        bus_we    = we_q;
        bus_addr  = {addr_q[31:2], 2'b00};
        bus_be    = be_q;
        bus_wdata = wdata_q;
        stall_m   = 1'b1;
        if (bus_ack) begin
          if (!we_q) rdata_d = load_extend(f3_q, addr_q[1:0], bus_rdata);
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and latched transaction registers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      addr_q  <= 32'b0;
      be_q    <= 4'b0;
      wdata_q <= 32'b0;
      we_q    <= 1'b0;
      f3_q    <= 3'b0;
      rdata_q <= 32'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_access.sv
// Randomised and directed bench for dmem_access against a size/offset
// arithmetic model of the data-bus access rules.
module tb_dmem_access;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        mem_re_m, mem_we_m;
  logic [31:0] alu_out_m, wdata_m;
  logic [2:0]  funct3_m;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic [31:0] mem_rdata_m;
  logic        stall_m, misalign_m;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_rdata = 32'h0;

  dmem_access dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .mem_re_m(mem_re_m), .mem_we_m(mem_we_m),
    .alu_out_m(alu_out_m), .wdata_m(wdata_m), .funct3_m(funct3_m),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .mem_rdata_m(mem_rdata_m), .stall_m(stall_m), .misalign_m(misalign_m)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---- reference model: access size in bytes drives everything ----
  function automatic int nbytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int n;
    logic [31:0] v;
    n = nbytes(f3);
    v = ((32'd1 << n) - 1) << a[1:0];
    return v & 32'hF;
  endfunction

  function automatic logic [31:0] m_lanes(input logic [2:0] f3, input logic [31:0] w);
    int n;
    n = nbytes(f3);
    if (n == 1) return {24'b0, w[7:0]} * 32'h0101_0101;
    if (n == 2) return {16'b0, w[15:0]} * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] rd);
    int n;
    logic [31:0] v;
    n = nbytes(f3);
    if (n == 4) return rd;
    v = (rd >> (8 * a[1:0])) & ((32'd1 << (8 * n)) - 1);
    if (!f3[2] && v[8*n-1]) v = v - (32'd1 << (8 * n));
    return v;
  endfunction

  task automatic idle_inputs();
    mem_re_m = 1'b0; mem_we_m = 1'b0;
    alu_out_m = $urandom; wdata_m = $urandom; funct3_m = 3'($urandom);
  endtask

  // One full access; starts shortly after a rising edge with the DUT in IDLE
  task automatic do_access(input logic re, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int waits, input logic [31:0] rd);
    logic mis;
    mis = (int'(addr[1:0]) % nbytes(f3)) != 0;
    mem_re_m = re; mem_we_m = we; funct3_m = f3; alu_out_m = addr; wdata_m = wd;
    bus_ack = 1'b0;
    #1;
    chk("req_misalign", {31'b0, misalign_m}, {31'b0, mis});
    chk("req_stall", {31'b0, stall_m}, {31'b0, !mis});
    chk("req_busreq", {31'b0, bus_req}, 32'h0);
    @(posedge clk_in); #1;
    idle_inputs();
    if (mis) begin
      #1;
      chk("mis_busreq", {31'b0, bus_req}, 32'h0);
      chk("mis_stall", {31'b0, stall_m}, 32'h0);
      chk("mis_rdata", mem_rdata_m, exp_rdata);
      return;
    end
    for (int w = 0; w <= waits; w++) begin
      bus_ack = (w == waits);
      bus_rdata = (w == waits) ? rd : $urandom;
      #1;
      chk("busy_req", {31'b0, bus_req}, 32'h1);
      chk("busy_stall", {31'b0, stall_m}, 32'h1);
      chk("busy_we", {31'b0, bus_we}, {31'b0, we});
      chk("busy_addr", bus_addr, {addr[31:2], 2'b00});
      chk("busy_be", {28'b0, bus_be}, m_be(f3, addr));
      if (we) chk("busy_wdata", bus_wdata, m_lanes(f3, wd));
      @(posedge clk_in); #1;
    end
    bus_ack = 1'b0; bus_rdata = $urandom;
    // a request presented in DONE must not be taken
    mem_re_m = 1'b1; funct3_m = 3'b010; alu_out_m = 32'h0000_0100;
    #1;
    if (!we) exp_rdata = m_load(f3, addr, rd);
    chk("done_stall", {31'b0, stall_m}, 32'h0);
    chk("done_busreq", {31'b0, bus_req}, 32'h0);
    chk("done_rdata", mem_rdata_m, exp_rdata);
    @(posedge clk_in); #1;
    idle_inputs();
    #1;
    chk("idle_busreq", {31'b0, bus_req}, 32'h0);
    chk("idle_stall", {31'b0, stall_m}, 32'h0);
    chk("idle_rdata", mem_rdata_m, exp_rdata);
  endtask

  initial begin
    rst_in = 1'b1; bus_ack = 1'b0; bus_rdata = 32'h0;
    idle_inputs();
    repeat (2) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    #1;
    chk("rst_busreq", {31'b0, bus_req}, 32'h0);
    chk("rst_stall", {31'b0, stall_m}, 32'h0);
    chk("rst_misalign", {31'b0, misalign_m}, 32'h0);
    chk("rst_rdata", mem_rdata_m, 32'h0);
    chk("rst_bus", {bus_we, bus_be, bus_addr[26:0]} | bus_wdata, 32'h0);

    // ack while idle is ignored
    bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    @(posedge clk_in); #1;
    bus_ack = 1'b0;
    #1;
    chk("idle_ack_req", {31'b0, bus_req}, 32'h0);
    chk("idle_ack_rdata", mem_rdata_m, 32'h0);

    // directed cases
    do_access(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0, 0, 32'h80FF_FF00);       // LB
    chk("lb_value", exp_rdata, 32'hFFFF_FF80);
    do_access(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 3, 32'h0);       // SH
    do_access(1'b1, 1'b0, 3'b010, 32'h0000_3001, 32'h0, 0, 32'h0);               // misaligned LW
    do_access(1'b1, 1'b0, 3'b101, 32'h0000_4002, 32'h0, 1, 32'h8001_0000);       // LHU
    chk("lhu_value", mem_rdata_m, 32'h0000_8001);
    do_access(1'b0, 1'b1, 3'b010, 32'h0000_5000, 32'hCAFE_F00D, 0, 32'h0);       // SW
    chk("sw_keeps_rdata", mem_rdata_m, 32'h0000_8001);
    do_access(1'b1, 1'b1, 3'b010, 32'h0000_6004, 32'h1111_2222, 2, 32'h5555_5555); // both -> store
    chk("both_keeps_rdata", mem_rdata_m, 32'h0000_8001);
    do_access(1'b1, 1'b0, 3'b001, 32'h0000_7002, 32'h0, 0, 32'h9ABC_0000);       // LH negative
    do_access(1'b1, 1'b0, 3'b001, 32'h0000_7003, 32'h0, 0, 32'h0);               // misaligned LH
    do_access(1'b1, 1'b0, 3'b111, 32'h0000_7002, 32'h0, 0, 32'h0);               // misaligned 111 word

    // reset in second BUSY cycle of a load, ack one cycle late
    mem_re_m = 1'b1; funct3_m = 3'b010; alu_out_m = 32'h0000_8000;
    @(posedge clk_in); #1;
    idle_inputs();
    @(posedge clk_in); #1;
    chk("rstmid_busy", {31'b0, bus_req}, 32'h1);
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    rst_in = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h7777_7777;
    #1;
    chk("rstmid_req", {31'b0, bus_req}, 32'h0);
    chk("rstmid_stall", {31'b0, stall_m}, 32'h0);
    chk("rstmid_rdata", mem_rdata_m, 32'h0);
    @(posedge clk_in); #1;
    bus_ack = 1'b0;
    #1;
    chk("late_ack_req", {31'b0, bus_req}, 32'h0);
    chk("late_ack_rdata", mem_rdata_m, 32'h0);
    exp_rdata = 32'h0;

    // randomised accesses
    for (int i = 0; i < 60; i++) begin
      logic re, we;
      re = 1'($urandom); we = 1'($urandom);
      if (!re && !we) re = 1'b1;
      do_access(re, we, 3'($urandom), $urandom, $urandom, int'($urandom_range(0, 3)), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
